// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 one-wire LED driver: FSM encoding and
// default bit timing for the 10 MHz build.
package ws2812_pkg;

  typedef enum logic {
    ST_LATCH = 1'b0,
    ST_SEND  = 1'b1
  } ws_state_e;

  localparam int unsigned WS_T0H          = 4;
  localparam int unsigned WS_T1H          = 8;
  localparam int unsigned WS_TBIT         = 12;
  localparam int unsigned WS_RESET_CYCLES = 600;
  localparam int unsigned WS_FRAME_BITS   = 24;

endpackage

// File: rtl/ws2812_bit_tx.sv
// One WS2812 bit period: 'go' starts a TBIT-clock period for bit_i, the line is
// high for T1H or T0H clocks, and last_phase_o marks the final clock of the period.
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H  = WS_T0H,
  parameter int unsigned T1H  = WS_T1H,
  parameter int unsigned TBIT = WS_TBIT
) (
  input  logic clk,
  input  logic reset,
  input  logic go_i,
  input  logic bit_i,
  output logic dout_o,
  output logic last_phase_o
);

  localparam int unsigned PW = $clog2(TBIT);
  localparam logic [PW-1:0] LAST = PW'(TBIT - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_inc;
  logic          active_q;
  logic          bit_q;
  logic          dout_q;

  function automatic logic high_at(input logic [PW-1:0] ph, input logic b);
    return b ? (32'(ph) < T1H) : (32'(ph) < T0H);
  endfunction

  assign phase_inc    = phase_q + 1'b1;
  assign last_phase_o = active_q && (phase_q == LAST);
  assign dout_o       = dout_q;

  // dout_q is loaded with the level of the phase being entered, so the line
  // always reflects the current phase straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      bit_q    <= 1'b0;
      dout_q   <= 1'b0;
    end else if (go_i) begin
      active_q <= 1'b1;
      phase_q  <= '0;
      bit_q    <= bit_i;
      dout_q   <= high_at('0, bit_i);
    end else if (active_q) begin
      if (phase_q == LAST) begin
        active_q <= 1'b0;
        phase_q  <= '0;
        dout_q   <= 1'b0;
      end else begin
        phase_q <= phase_inc;
        dout_q  <= high_at(phase_inc, bit_q);
      end
    end
  end

endmodule

// File: rtl/ws2812_driver.sv
// Free-running WS2812 driver: latch period, then 24 bits {G,R,B} MSB first,
// repeated while enable is high. Colour inputs are snapshotted at frame start.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H          = WS_T0H,
  parameter int unsigned T1H          = WS_T1H,
  parameter int unsigned TBIT         = WS_TBIT,
  parameter int unsigned RESET_CYCLES = WS_RESET_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned LW = $clog2(RESET_CYCLES);
  localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [4:0]    BIT_LAST   = 5'(WS_FRAME_BITS - 1);

  ws_state_e     state_q;
  logic [LW-1:0] latch_cnt_q;
  logic [4:0]    bit_idx_q;
  logic [23:0]   shift_q;
  logic          busy_q;
  logic          frame_done_q;

  logic latch_done;
  logic last_bit;
  logic tx_last;
  logic tx_go;
  logic tx_bit;
  logic tx_dout;

  assign latch_done = (state_q == ST_LATCH) && (latch_cnt_q == LATCH_LAST);
  assign last_bit   = (bit_idx_q == BIT_LAST);
  assign tx_go      = (latch_done && enable) ||
                      ((state_q == ST_SEND) && tx_last && !last_bit);
  // The first bit goes straight from the inputs; shift_q then holds the
  // remaining bits left-aligned so bit 23 is always the next one to send.
  assign tx_bit     = (state_q == ST_LATCH) ? green[7] : shift_q[23];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LATCH;
      latch_cnt_q  <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_LATCH: begin
          if (latch_cnt_q != LATCH_LAST) begin
            latch_cnt_q <= latch_cnt_q + 1'b1;
          end else if (enable) begin
            state_q   <= ST_SEND;
            shift_q   <= {green[6:0], red, blue, 1'b0};
            bit_idx_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_last) begin
            if (last_bit) begin
              state_q      <= ST_LATCH;
              latch_cnt_q  <= '0;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= {shift_q[22:0], 1'b0};
            end
          end
        end
        default: state_q <= ST_LATCH;
      endcase
    end
  end

  ws2812_bit_tx #(
    .T0H (T0H),
    .T1H (T1H),
    .TBIT(TBIT)
  ) u_bit_tx (
    .clk         (clk),
    .reset       (reset),
    .go_i        (tx_go),
    .bit_i       (tx_bit),
    .dout_o      (tx_dout),
    .last_phase_o(tx_last)
  );

  assign dout       = tx_dout;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: cycle-level waveform model built from frame start
// times and values, plus a line decoder checked against the expected frame list.
module tb_ws2812_driver;

  localparam int T0H   = 4;
  localparam int T1H   = 8;
  localparam int TBIT  = 12;
  localparam int RST   = 600;
  localparam int FRAME = 24 * TBIT;
  localparam int PER   = FRAME + RST;

  // ---------------- clock / reset / DUT ----------------
  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] red    = 8'h00;
  logic [7:0] green  = 8'h00;
  logic [7:0] blue   = 8'h00;
  logic       dout;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  ws2812_driver dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // cycle 0 is the first cycle with reset low
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          fr_start_q[$];
  logic [23:0] fr_val_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  int          fd_cyc_q[$];
  int dout_mm = 0;
  int busy_mm = 0;
  int fd_mm   = 0;
  int busy_cnt = 0;

  // {dout, busy, frame_done} expected at cycle t from the frames scheduled so far
  function automatic logic [2:0] model_at(input int t);
    logic d;
    logic b;
    logic f;
    d = 1'b0;
    b = 1'b0;
    f = 1'b0;
    foreach (fr_start_q[i]) begin
      int k;
      k = t - fr_start_q[i];
      if (k >= 0 && k < FRAME) begin
        logic bv;
        b  = 1'b1;
        bv = fr_val_q[i][23 - k / TBIT];
        d  = (k % TBIT) < (bv ? T1H : T0H);
      end else if (k == FRAME) begin
        f = 1'b1;
      end
    end
    return {d, b, f};
  endfunction

  task automatic add_frame(input int start, input logic [23:0] v, input bit complete);
    fr_start_q.push_back(start);
    fr_val_q.push_back(v);
    if (complete) exp_q.push_back(v);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_dout_wave"}, dout_mm, 0);
    check_eq({tag, "_busy_wave"}, busy_mm, 0);
    check_eq({tag, "_done_wave"}, fd_mm, 0);
    dout_mm = 0;
    busy_mm = 0;
    fd_mm   = 0;
  endtask

  // ---------------- monitor + line decoder ----------------
  logic        prev_d = 1'b0;
  int          rise_c = 0;
  int          last_rise = -1000;
  int          nbits = 0;
  logic [23:0] word = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_d    = 1'b0;
      nbits     = 0;
      last_rise = -1000;
    end else begin
      logic [2:0] e;
      e = model_at(cyc);
      if (dout !== e[2])       dout_mm++;
      if (busy !== e[1])       busy_mm++;
      if (frame_done !== e[0]) fd_mm++;
      if (busy === 1'b1)       busy_cnt++;
      if (frame_done === 1'b1) fd_cyc_q.push_back(cyc);
      if (dout && !prev_d) begin
        if (cyc - last_rise > TBIT) nbits = 0;
        rise_c    = cyc;
        last_rise = cyc;
      end
      if (!dout && prev_d) begin
        word = {word[22:0], ((cyc - rise_c) >= (T0H + T1H) / 2)};
        nbits++;
        if (nbits == 24) begin
          got_q.push_back(word);
          nbits = 0;
        end
      end
      prev_d = dout;
    end
  end

  // ---------------- driver tasks ----------------
  // advance to posedge+1 of cycle n (caller is in an earlier cycle)
  task automatic goto(input int n);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc < n && guard < 20000);
    if (cyc < n) check_eq("goto_timeout", cyc, n);
  endtask

  task automatic sample(input int n);
    goto(n);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    fr_start_q.delete();
    fr_val_q.delete();
    fd_cyc_q.delete();
    busy_cnt = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] rv;
    logic [23:0] rv2;
    logic [23:0] rnd;

    {green, red, blue} = 24'h00FFA5;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    add_frame(RST, 24'h00FFA5, 1'b1);

    @(negedge clk);
    check_eq("reset_dout", dout, 1'b0);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", frame_done, 1'b0);
    sample(RST - 1);
    check_eq("latch_last_low", dout, 1'b0);
    sample(RST);
    check_eq("first_high", dout, 1'b1);
    check_eq("first_busy", busy, 1'b1);

    // red changes mid-frame: current frame unaffected
    goto(RST + 5 * TBIT);
    red = 8'h00;
    add_frame(RST + PER, 24'h0000A5, 1'b1);
    add_frame(RST + 2 * PER, 24'h0000A5, 1'b1);

    goto(2700);
    rv = 24'($urandom);
    {green, red, blue} = rv;
    add_frame(RST + 3 * PER, rv, 1'b1);

    goto(3000);
    check_eq("free_pulses", fd_cyc_q.size(), 3);
    if (fd_cyc_q.size() == 3) begin
      check_eq("free_first_done", fd_cyc_q[0], RST + FRAME);
      check_eq("free_gap1", fd_cyc_q[1] - fd_cyc_q[0], PER);
      check_eq("free_gap2", fd_cyc_q[2] - fd_cyc_q[1], PER);
    end
    check_eq("free_busy_cycles", busy_cnt, 3 * FRAME);
    check_model("free_run");

    // enable dropped at bit 10: frame completes, then idle
    goto(RST + 3 * PER + 10 * TBIT);
    enable = 1'b0;
    sample(5150);
    check_eq("idle_dout", dout, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_pulses", fd_cyc_q.size(), 4);
    goto(5151);
    rv2 = 24'($urandom);
    {green, red, blue} = rv2;
    enable = 1'b1;
    add_frame(5152, rv2, 1'b0);
    sample(5152);
    check_eq("reenable_high", dout, 1'b1);
    check_model("enable");

    // reset at bit 12, then all-zero and all-ones frames
    goto(5152 + 12 * TBIT - 1);
    pulse_reset();
    {green, red, blue} = 24'h000000;
    add_frame(RST, 24'h000000, 1'b1);
    @(negedge clk);
    check_eq("midreset_dout", dout, 1'b0);
    check_eq("midreset_busy", busy, 1'b0);
    sample(RST - 1);
    check_eq("restart_low", dout, 1'b0);
    sample(RST);
    check_eq("restart_high", dout, 1'b1);
    goto(700);
    {green, red, blue} = 24'hFFFFFF;
    add_frame(RST + PER, 24'hFFFFFF, 1'b1);
    goto(1600);
    enable = 1'b0;

    // random back-to-back frames
    goto(2500);
    rnd = 24'($urandom);
    {green, red, blue} = rnd;
    enable = 1'b1;
    add_frame(2501, rnd, 1'b1);
    for (int i = 1; i < 4; i++) begin
      goto(2501 + PER * (i - 1) + $urandom_range(10, 250));
      rnd = 24'($urandom);
      {green, red, blue} = rnd;
      add_frame(2501 + PER * i, rnd, 1'b1);
    end
    goto(2501 + PER * 3 + 100);
    enable = 1'b0;
    goto(6500);
    check_eq("rand_pulses", fd_cyc_q.size(), 6);
    check_model("rand");

    check_eq("decode_count", got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < got_q.size()) check_eq($sformatf("decode_frame%0d", i), got_q[i], exp_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
